vote_accum_engine: RTL
======================

VOTE_ACCUM_ENGINE -- requirements
Module: vote_accum_engine

Interface
REQ-001 Parameters: N_LABELS=10, max labels per slot; LBL_W=4, label index width; RES_WIDTH=16, vote word width; N_SLOTS=256, number of vote slots; SLOT_W=8, slot index width; ADDR_W=12, memory address width, which shall satisfy 2^ADDR_W >= N_SLOTS*N_LABELS.
REQ-002 Ports are listed below as name, direction, width, meaning.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_n_labels  in  LBL_W  labels in use.
REQ-006 i_is_clf  in  1  1 = classification mode, 0 = regression mode.
REQ-007 i_vld  in  1  input update valid.
REQ-008 o_rdy  out  1  block can accept an update.
REQ-009 i_slot  in  SLOT_W  target slot.
REQ-010 i_clf_accum  in  N_LABELS*RES_WIDTH  per-label votes, label k in bits [k*RES_WIDTH +: RES_WIDTH].
REQ-011 i_rgs_accum  in  RES_WIDTH  regression value.
REQ-012 i_clear  in  1  request to zero the whole memory.
REQ-013 o_busy  out  1  scan, clear or pipeline activity in progress.
REQ-014 i_rd_en  in  1  host read strobe.
REQ-015 i_rd_addr  in  ADDR_W  host read address.
REQ-016 o_rd_data  out  RES_WIDTH  host read data.
REQ-017 o_rd_vld  out  1  o_rd_data valid.
REQ-018 o_rd_drop  out  1  1-cycle pulse; host read rejected.
REQ-019 o_overflow  out  1  sticky saturation flag.

Function
REQ-020 Memory: N_SLOTS*N_LABELS words of RES_WIDTH, inferred internally; registered read, read-first, one read port plus one write port; word address = slot*N_LABELS+label.
REQ-021 FSM states: IDLE, SCAN, DRAIN, CLEAR.
REQ-022 o_rdy = (state==IDLE) && !i_clear; an update is accepted when i_vld && o_rdy.
REQ-023 Classification accept at cycle t: latch slot, i_clf_accum and n_eff, where n_eff = i_n_labels clamped to the range 1..N_LABELS; go to SCAN.
REQ-024 SCAN issues labels 0..n_eff-1, one per cycle, in cycles t+1..t+n_eff; o_rdy=0 throughout; returns to IDLE after the last issue.
REQ-025 Regression accept at cycle t: issue one update to word slot*N_LABELS at t+1; stay in IDLE, so throughput is 1 update/cycle.
REQ-026 Update pipeline for an update issued at cycle c: memory read at the end of c; sum formed in c+1; write at the end of c+1; the new value is readable from cycle c+2.
REQ-027 Hazard forwarding: if the write committed at the end of c targets the same address, the sum in c+1 uses that written value, not memory data, so back-to-back same-address updates never lose votes.
REQ-028 Sum arithmetic: unsigned, saturating at 2^RES_WIDTH-1; on saturation o_overflow is set from the next cycle and held until clear or rst.
REQ-029 i_clear sampled in IDLE (takes priority over i_vld that cycle): go to DRAIN until no update is in flight.
REQ-030 CLEAR state: write 0 to addresses 0..N_SLOTS*N_LABELS-1, one per cycle, then return to IDLE.
REQ-031 o_overflow is cleared on entry to CLEAR.
REQ-032 i_clear outside IDLE is ignored.
REQ-033 o_busy = 1 when state != IDLE or any pipeline stage is valid.
REQ-034 Host read accepted when i_rd_en && !o_busy && no update issued that cycle: o_rd_data and o_rd_vld=1 appear in the next cycle.
REQ-035 Host read otherwise: o_rd_drop=1 in the next cycle and o_rd_vld=0.

Reset
REQ-036 rst: state=IDLE; all pipeline valids=0; o_rdy=1 from the first cycle after rst deasserts; o_busy=0, o_rd_vld=0, o_rd_drop=0, o_overflow=0, o_rd_data=0.
REQ-037 rst: the scan counter and latched inputs are zeroed; memory contents are not reset (software issues i_clear).
REQ-038 rst mid-SCAN or mid-CLEAR: in-flight updates are discarded and no memory write occurs in any cycle where rst=1.

Verification
REQ-039 Classification: slot=2, n_labels=3, accum {5,7,9}, accepted twice after a clear -> words 20,21,22 = 10,14,18; o_rdy low 3 cycles per accept.
REQ-040 Regression back-to-back: slot=4, values 1,2,3 in consecutive cycles -> word 40 = 6 (forwarding exercised); o_rdy stays 1.
REQ-041 Saturation: word 0 = 0xFFF0, regression add 0x0020 -> word 0 = 0xFFFF, o_overflow=1 until the next clear.
REQ-042 Clear: i_clear in IDLE -> o_busy high for at least 2560 cycles; every host read afterwards returns 0; o_overflow=0.
REQ-043 Read conflict: i_rd_en during SCAN -> o_rd_drop pulse, o_rd_vld=0; same read in IDLE -> o_rd_vld after 1 cycle.
REQ-044 rst asserted mid-SCAN with n_labels=10 at label 4 -> labels 5..9 unchanged, o_rdy=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/vote_accum_engine.sv
// Vote accumulation engine: per-slot label votes summed into an internal memory,
// with a saturating read-modify-write pipeline, a bulk clear and a host read port.
module vote_accum_engine #(
  parameter int unsigned N_LABELS  = 10,
  parameter int unsigned LBL_W     = 4,
  parameter int unsigned RES_WIDTH = 16,
  parameter int unsigned N_SLOTS   = 256,
  parameter int unsigned SLOT_W    = 8,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LBL_W-1:0]              i_n_labels,
  input  logic                          i_is_clf,
  input  logic                          i_vld,
  output logic                          o_rdy,
  input  logic [SLOT_W-1:0]             i_slot,
  input  logic [N_LABELS*RES_WIDTH-1:0] i_clf_accum,
  input  logic [RES_WIDTH-1:0]          i_rgs_accum,
  input  logic                          i_clear,
  output logic                          o_busy,
  input  logic                          i_rd_en,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic [RES_WIDTH-1:0]          o_rd_data,
  output logic                          o_rd_vld,
  output logic                          o_rd_drop,
  output logic                          o_overflow
);

  localparam int unsigned DEPTH = N_SLOTS * N_LABELS;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, CLEAR} state_t;

  state_t                        state;
  logic [LBL_W-1:0]              cnt;
  logic [LBL_W-1:0]              n_eff_q;
  logic [SLOT_W-1:0]             slot_q;
  logic [N_LABELS*RES_WIDTH-1:0] clf_q;
  logic                          rgs_pend;
  logic [ADDR_W-1:0]             rgs_addr_q;
  logic [RES_WIDTH-1:0]          rgs_val_q;
  logic [ADDR_W-1:0]             clr_addr;
  logic                          s2_vld;
  logic [ADDR_W-1:0]             s2_addr;
  logic [RES_WIDTH-1:0]          s2_val;
  logic                          wq_vld;
  logic [ADDR_W-1:0]             wq_addr;
  logic [RES_WIDTH-1:0]          wq_data;
  logic [RES_WIDTH-1:0]          mem [DEPTH];
  logic [RES_WIDTH-1:0]          rd_q;

  logic [LBL_W-1:0]              n_eff_c;
  logic                          iss_vld;
  logic [ADDR_W-1:0]             iss_addr;
  logic [RES_WIDTH-1:0]          iss_val;
  logic [ADDR_W-1:0]             rd_addr;
  logic                          rd_ok;
  logic [RES_WIDTH-1:0]          base;
  logic [RES_WIDTH:0]            sum_full;
  logic                          sat;
  logic [RES_WIDTH-1:0]          sum;
  logic                          we;
  logic [ADDR_W-1:0]             wa;
  logic [RES_WIDTH-1:0]          wd;

  assign o_rdy     = (state == IDLE) && !i_clear;
  assign o_busy    = (state != IDLE) || rgs_pend || s2_vld;
  assign o_rd_data = rd_q;

  always_comb begin
    n_eff_c = i_n_labels;
    if (i_n_labels == '0)
      n_eff_c = LBL_W'(1);
    else if (i_n_labels > LBL_W'(N_LABELS))
      n_eff_c = LBL_W'(N_LABELS);
  end

  // Issue stage: SCAN and a pending regression update are mutually exclusive in time.
  always_comb begin
    iss_vld  = (state == SCAN) || rgs_pend;
    iss_addr = rgs_addr_q;
    iss_val  = rgs_val_q;
    if (state == SCAN) begin
      iss_addr = ADDR_W'(ADDR_W'(slot_q) * ADDR_W'(N_LABELS) + ADDR_W'(cnt));
      iss_val  = clf_q[int'(cnt)*RES_WIDTH +: RES_WIDTH];
    end
    rd_ok   = i_rd_en && !o_busy && !iss_vld;
    rd_addr = iss_vld ? iss_addr : i_rd_addr;
  end

  // Sum stage; forward the previous cycle's write since the read-first port missed it.
  always_comb begin
    base     = (wq_vld && (wq_addr == s2_addr)) ? wq_data : rd_q;
    sum_full = {1'b0, base} + {1'b0, s2_val};
    sat      = sum_full[RES_WIDTH];
    sum      = sat ? '1 : sum_full[RES_WIDTH-1:0];
    we       = !rst && ((state == CLEAR) || s2_vld);
    wa       = (state == CLEAR) ? clr_addr : s2_addr;
    wd       = (state == CLEAR) ? '0 : sum;
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_q <= '0;
    else
      rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      n_eff_q    <= '0;
      slot_q     <= '0;
      clf_q      <= '0;
      rgs_pend   <= 1'b0;
      rgs_addr_q <= '0;
      rgs_val_q  <= '0;
      clr_addr   <= '0;
      s2_vld     <= 1'b0;
      s2_addr    <= '0;
      s2_val     <= '0;
      wq_vld     <= 1'b0;
      wq_addr    <= '0;
      wq_data    <= '0;
      o_rd_vld   <= 1'b0;
      o_rd_drop  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      rgs_pend  <= 1'b0;
      s2_vld    <= iss_vld;
      s2_addr   <= iss_addr;
      s2_val    <= iss_val;
      wq_vld    <= s2_vld;
      wq_addr   <= s2_addr;
      wq_data   <= sum;
      o_rd_vld  <= rd_ok;
      o_rd_drop <= i_rd_en && !rd_ok;
      if (s2_vld && sat)
        o_overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (i_clear) begin
            state <= DRAIN;
          end else if (i_vld) begin
            if (i_is_clf) begin
              state   <= SCAN;
              slot_q  <= i_slot;
              clf_q   <= i_clf_accum;
              n_eff_q <= n_eff_c;
              cnt     <= '0;
            end else begin
              rgs_pend   <= 1'b1;
              rgs_addr_q <= ADDR_W'(ADDR_W'(i_slot) * ADDR_W'(N_LABELS));
              rgs_val_q  <= i_rgs_accum;
            end
          end
        end
        SCAN: begin
          if (cnt == n_eff_q - LBL_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LBL_W'(1);
          end
        end
        DRAIN: begin
          if (!rgs_pend && !s2_vld) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            o_overflow <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_addr == ADDR_W'(DEPTH - 1))
            state <= IDLE;
          clr_addr <= clr_addr + ADDR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
